// File: rtl/imem_boot_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words and writes them to imem from address 0.
// Optional build macro CHECKSUM_EN adds a trailing 32-bit sum check before releasing the CPU.
module imem_boot_loader #(
  parameter int DEPTH = 256,
  parameter int LEN_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] load_len,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, CHECK, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
`endif

  state_t           state, state_n;
  logic [AW-1:0]    wcnt;
  logic [1:0]       bcnt;
  logic [LEN_W-1:0] len_q;
  logic [31:0]      word_q;
  logic             error_q;
  logic             accept, start_ok, last_word;
`ifdef CHECKSUM_EN
  logic [31:0]      sum_q;
  logic [31:0]      chk_q;
`endif

  assign accept    = byte_valid && byte_ready;
  assign start_ok  = start && (state == IDLE || state == DONE);
  assign last_word = (LEN_W'(wcnt) == len_q - LEN_W'(1));
  assign mem_addr  = {{(32-AW){1'b0}}, wcnt};
  assign mem_wdata = word_q;
  assign error     = error_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    cpu_hold   = 1'b1;
    case (state)
      IDLE, DONE: begin
        if (state == DONE) begin
          done     = 1'b1;
          cpu_hold = error_q;
        end
        if (start) begin
          // zero-length and oversize loads both finish immediately
          if (load_len == '0 || load_len > DEPTH_L) state_n = DONE;
          else                                       state_n = LOAD;
        end
      end
      LOAD: begin
        byte_ready = 1'b1;
        if (accept && bcnt == 2'd3) state_n = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
`ifdef CHECKSUM_EN
        state_n = last_word ? CHECK : LOAD;
`else
        state_n = last_word ? DONE : LOAD;
`endif
      end
`ifdef CHECKSUM_EN
      CHECK: begin
        byte_ready = 1'b1;
        if (accept && bcnt == 2'd3) state_n = DONE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt    <= '0;
      bcnt    <= '0;
      len_q   <= '0;
      word_q  <= '0;
      error_q <= 1'b0;
`ifdef CHECKSUM_EN
      sum_q   <= '0;
      chk_q   <= '0;
`endif
    end else begin
      if (start_ok) begin
        len_q   <= load_len;
        wcnt    <= '0;
        bcnt    <= '0;
        error_q <= (load_len > DEPTH_L);
`ifdef CHECKSUM_EN
        sum_q   <= '0;
`endif
      end
      if (accept) begin
        bcnt <= bcnt + 2'd1;
        // shifting in from the bottom leaves the first byte in the MSB after four bytes
        if (state == LOAD) word_q <= {word_q[23:0], byte_in};
`ifdef CHECKSUM_EN
        if (state == CHECK) begin
          chk_q <= {chk_q[23:0], byte_in};
          if (bcnt == 2'd3) error_q <= ({chk_q[23:0], byte_in} != sum_q);
        end
`endif
      end
      if (state == WRITE) begin
        // hold on the final word so the counter stays within DEPTH-1
        if (!last_word) wcnt <= wcnt + AW'(1);
`ifdef CHECKSUM_EN
        sum_q <= sum_q + word_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: vector table plus hand sequences for reset, stalls and the full-depth load.
module tb_imem_boot_loader;
  localparam int DEPTH = 256;
  localparam int LEN_W = 9;

  logic             clk = 1'b0;
  logic             reset, start, byte_valid;
  logic [LEN_W-1:0] load_len;
  logic [7:0]       byte_in;
  logic             byte_ready, mem_we, cpu_hold, done, error;
  logic [31:0]      mem_addr, mem_wdata;

  always #5 clk = ~clk;

  imem_boot_loader #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  int nchk = 0, nfail = 0;
  int wr_n = 0, rdy_bad = 0;
  logic [31:0] wr_a [0:1023];
  logic [31:0] wr_d [0:1023];

  always @(negedge clk) begin
    if (mem_we && wr_n < 1024) begin
      wr_a[wr_n] = mem_addr;
      wr_d[wr_n] = mem_wdata;
      wr_n++;
    end
    if (byte_ready && (mem_we || done)) rdy_bad++;
  end

  typedef struct packed {
    logic [8:0]  len;
    logic [95:0] bytes;   // stream, first byte in the MSBs
    logic [95:0] exp;     // expected words, word 0 in the MSBs
    logic [31:0] chk;     // expected-sum bytes sent when the checksum build is used
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic do_start(input logic [LEN_W-1:0] len);
    start = 1'b1; load_len = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b[$], input bit toggle, input int start_at);
    int  i = 0, g = 0;
    bit  ph = 1'b1, acc, pulsed = 1'b0;
    while (i < b.size() && g < 5000) begin
      byte_in = b[i];
      byte_valid = toggle ? ph : 1'b1;
      if (start_at >= 0 && i == start_at && !pulsed) begin
        start = 1'b1; load_len = 9'd5; pulsed = 1'b1;
      end
      @(negedge clk);
      acc = byte_valid && byte_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) i++;
      ph = ~ph;
      g++;
    end
    byte_valid = 1'b0;
    if (g >= 5000) check("send_bound", i, b.size());
  endtask

  task automatic wait_done();
    int g = 0;
    while (!done && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check("done_bound", {31'd0, done}, 32'd1);
  endtask

  task automatic push_word(inout logic [7:0] q[$], input logic [31:0] w);
    for (int k = 0; k < 4; k++) q.push_back(w[31-8*k -: 8]);
  endtask

  initial begin
    logic [7:0]  q[$];
    logic [31:0] w, sum;
    int base, bad;

    vecs[0] = '{9'd2, 96'h20080005_8C090004_00000000, 96'h20080005_8C090004_00000000, 32'hAC110009, 1'b0};
    vecs[1] = '{9'd1, 96'hDEADBEEF_00000000_00000000, 96'hDEADBEEF_00000000_00000000, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{9'd0, 96'h0, 96'h0, 32'h0, 1'b0};
    vecs[3] = '{9'd257, 96'h0, 96'h0, 32'h0, 1'b1};
    vecs[4] = '{9'd511, 96'h0, 96'h0, 32'h0, 1'b1};
    vecs[5] = '{9'd3, 96'h01020304_05060708_090A0B0C, 96'h01020304_05060708_090A0B0C, 32'h0F121518, 1'b0};

    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = '0; load_len = '0;
    #1;
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_mem_we",     {31'd0, mem_we},     32'd0);
    check("rst_mem_addr",   mem_addr,            32'd0);
    check("rst_mem_wdata",  mem_wdata,           32'd0);
    check("rst_cpu_hold",   {31'd0, cpu_hold},   32'd1);
    check("rst_done",       {31'd0, done},       32'd0);
    check("rst_error",      {31'd0, error},      32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // reset after two bytes of a load
    do_start(9'd2);
    q = {8'hA1, 8'hB2};
    send(q, 1'b0, -1);
    reset = 1'b1;
    #1;
    check("midrst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("midrst_mem_wdata",  mem_wdata,           32'd0);
    check("midrst_mem_addr",   mem_addr,            32'd0);
    check("midrst_cpu_hold",   {31'd0, cpu_hold},   32'd1);
    check("midrst_done",       {31'd0, done},       32'd0);
    @(posedge clk); #1 reset = 1'b0;
    base = wr_n;
    do_start(9'd1);
    q = {8'h11, 8'h22, 8'h33, 8'h44};
    send(q, 1'b0, -1);
    check("latency_mem_we", {31'd0, mem_we}, 32'd1);
`ifdef CHECKSUM_EN
    q = {8'h11, 8'h22, 8'h33, 8'h44};
    send(q, 1'b0, -1);
`endif
    wait_done();
    check("postrst_nwr",  wr_n - base,        32'd1);
    check("postrst_addr", wr_a[base],         32'd0);
    check("postrst_data", wr_d[base],         32'h11223344);
    check("postrst_hold", {31'd0, cpu_hold},  32'd0);

    // table: byte_valid held high
    foreach (vecs[v]) begin
      base = wr_n;
      do_start(vecs[v].len);
      if (vecs[v].len == 0 || vecs[v].len > DEPTH) begin
        check($sformatf("v%0d_done_next", v), {31'd0, done}, 32'd1);
      end else begin
        check($sformatf("v%0d_done_clr", v), {31'd0, done}, 32'd0);
        check($sformatf("v%0d_hold_busy", v), {31'd0, cpu_hold}, 32'd1);
        q = {};
        for (int k = 0; k < 4 * int'(vecs[v].len); k++) q.push_back(vecs[v].bytes[95-8*k -: 8]);
`ifdef CHECKSUM_EN
        push_word(q, vecs[v].chk);
`endif
        send(q, 1'b0, -1);
        wait_done();
      end
      check($sformatf("v%0d_error", v), {31'd0, error},    {31'd0, vecs[v].exp_err});
      check($sformatf("v%0d_hold", v),  {31'd0, cpu_hold}, {31'd0, vecs[v].exp_err});
      check($sformatf("v%0d_nwr", v),   wr_n - base, vecs[v].exp_err ? 32'd0 : 32'(vecs[v].len));
      for (int k = 0; k < int'(vecs[v].len) && k < 3 && !vecs[v].exp_err; k++) begin
        check($sformatf("v%0d_addr%0d", v, k), wr_a[base+k], 32'(k));
        check($sformatf("v%0d_data%0d", v, k), wr_d[base+k], vecs[v].exp[95-32*k -: 32]);
      end
    end

    // toggled byte_valid with a start pulse mid-load
    base = wr_n;
    do_start(9'd1);
    q = {8'hCA, 8'hFE, 8'hF0, 8'h0D};
`ifdef CHECKSUM_EN
    push_word(q, 32'hCAFEF00D);
`endif
    send(q, 1'b1, 2);
    wait_done();
    check("tog_nwr",   wr_n - base,       32'd1);
    check("tog_data",  wr_d[base],        32'hCAFEF00D);
    check("tog_error", {31'd0, error},    32'd0);

    // full-depth load
    base = wr_n;
    sum = '0;
    q = {};
    for (int i = 0; i < DEPTH; i++) begin
      w = {8'(i), ~8'(i), 8'h5A, 8'(i) ^ 8'h33};
      sum = sum + w;
      push_word(q, w);
    end
`ifdef CHECKSUM_EN
    push_word(q, sum);
`endif
    do_start(9'd256);
    send(q, 1'b0, -1);
    wait_done();
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      w = {8'(i), ~8'(i), 8'h5A, 8'(i) ^ 8'h33};
      if (wr_a[base+i] !== 32'(i) || wr_d[base+i] !== w) bad++;
    end
    check("full_nwr",   wr_n - base,        32'd256);
    check("full_words", bad,                32'd0);
    check("full_last",  wr_a[base+255],     32'd255);
    check("full_hold",  {31'd0, cpu_hold},  32'd0);

`ifdef CHECKSUM_EN
    for (int t = 0; t < 2; t++) begin
      base = wr_n;
      q = {};
      push_word(q, 32'h00000001);
      push_word(q, 32'hFFFFFFFF);
      push_word(q, (t == 0) ? 32'h00000000 : 32'h00000001);
      do_start(9'd2);
      send(q, 1'b0, -1);
      wait_done();
      check($sformatf("cs%0d_nwr", t),   wr_n - base,       32'd2);
      check($sformatf("cs%0d_error", t), {31'd0, error},    (t == 0) ? 32'd0 : 32'd1);
      check($sformatf("cs%0d_hold", t),  {31'd0, cpu_hold}, (t == 0) ? 32'd0 : 32'd1);
    end
`endif

    // bytes offered while not loading are ignored
    base = wr_n;
    byte_valid = 1'b1; byte_in = 8'hFF;
    repeat (5) @(posedge clk);
    #1;
    check("idle_ready", {31'd0, byte_ready}, 32'd0);
    byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_nwr", wr_n - base, 32'd0);
    check("ready_outside_load", rdy_bad, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
